// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path: fetch state encoding,
// instruction field positions and opcode values also used by the control FSM.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_W = 16;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 10;
    localparam int unsigned RS_HI  = 9;
    localparam int unsigned RS_LO  = 8;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;

    localparam logic [3:0] OP_MOVEB = 4'b0000;
    localparam logic [3:0] OP_MOVEA = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_ADD2  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_AND2  = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_JUMP  = 4'b1010;
    localparam logic [3:0] OP_JZ    = 4'b1011;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory-response watchdog: clears on request, counts each unanswered wait
// cycle and flags the cycle in which the TIMEOUT-th wait elapses.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // The abort fires at LAST, so count never exceeds TIMEOUT and cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = en && (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch responder: on a request pulse reads instruction memory at the PC,
// latches and decodes the instruction and returns a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for en_in; latches pc_addr into mem_addr on request
// REQ   | read strobe cycle; watchdog cleared; zero-wait data accepted
// WAIT  | waiting for mem_valid; aborts with err after TIMEOUT cycles
// DONE  | en_out pulse; decoded fields valid
module instr_fetch_unit #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_in,
    input  logic [PC_W-1:0]    pc_addr,
    output logic [PC_W-1:0]    mem_addr,
    output logic               mem_rd_en,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [7:0]         imm,
    output logic               en_out,
    output logic               busy,
    output logic               err,
    output logic               ovr
);

    import instr_fetch_unit_pkg::*;

    fetch_state_t state, next_state;
    logic ctr_clr, ctr_en, ctr_tc;
    logic accept, load_ir, time_out;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (ctr_en),
        .tc  (ctr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load_ir    = 1'b0;
        time_out   = 1'b0;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en_in) begin
                    accept     = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                ctr_clr = 1'b1;
                if (mem_valid) begin
                    load_ir    = 1'b1;
                    next_state = DONE;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    load_ir    = 1'b1;
                    next_state = DONE;
                end else begin
                    ctr_en = 1'b1;
                    if (ctr_tc) begin
                        time_out   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Sticky flags clear only on reset; a request while busy is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            ir       <= '0;
            err      <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr <= pc_addr;
            end
            if (load_ir) begin
                ir <= mem_rdata;
            end
            if (time_out) begin
                err <= 1'b1;
            end
            if (en_in && (state != IDLE)) begin
                ovr <= 1'b1;
            end
        end
    end

    assign mem_rd_en = (state == REQ);
    assign en_out    = (state == DONE);
    assign busy      = (state != IDLE);

    assign opcode = ir[OPC_HI:OPC_LO];
    assign rd     = ir[RD_HI:RD_LO];
    assign rs     = ir[RS_HI:RS_LO];
    assign imm    = ir[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (TIMEOUT=8): reset, normal, zero-wait,
// timeout, overrun and reset-during-fetch scenarios with fixed expectations.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        en_in;
   logic [7:0]  pc_addr;
   logic [7:0]  mem_addr;
   logic        mem_rd_en;
   logic [15:0] mem_rdata;
   logic        mem_valid;
   logic [15:0] ir;
   logic [3:0]  opcode;
   logic [1:0]  rd;
   logic [1:0]  rs;
   logic [7:0]  imm;
   logic        en_out;
   logic        busy;
   logic        err;
   logic        ovr;

   int tests = 0;
   int fails = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   int rd_base;
   int done_base;

   instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .TIMEOUT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en_in     (en_in),
      .pc_addr   (pc_addr),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .ir        (ir),
      .opcode    (opcode),
      .rd        (rd),
      .rs        (rs),
      .imm       (imm),
      .en_out    (en_out),
      .busy      (busy),
      .err       (err),
      .ovr       (ovr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (mem_rd_en) rd_cnt++;
      if (en_out) done_cnt++;
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; en_in = 1'b0; pc_addr = 8'h00; mem_rdata = 16'h0000; mem_valid = 1'b0;
      #3;
      check("rst_busy", busy, 1'b0);
      check("rst_ir", ir, 16'h0000);
      check("rst_addr", mem_addr, 8'h00);
      check("rst_flags", {mem_rd_en, en_out, err, ovr}, 4'b0000);
      #9;
      rst = 1'b0;

      // normal fetch, data arrives in cycle 3
      next_cycle();
      rd_base = rd_cnt; done_base = done_cnt;
      en_in = 1'b1; pc_addr = 8'h05;
      check("nf_c0_busy", busy, 1'b0);
      next_cycle();
      en_in = 1'b0; pc_addr = 8'hEE;
      check("nf_c1_rd_en", mem_rd_en, 1'b1);
      check("nf_c1_addr", mem_addr, 8'h05);
      check("nf_c1_busy", busy, 1'b1);
      next_cycle();
      check("nf_c2_rd_en", mem_rd_en, 1'b0);
      check("nf_c2_en_out", en_out, 1'b0);
      next_cycle();
      mem_valid = 1'b1; mem_rdata = 16'h2A37;
      check("nf_c3_en_out", en_out, 1'b0);
      check("nf_c3_busy", busy, 1'b1);
      next_cycle();
      mem_valid = 1'b0; mem_rdata = 16'h0000;
      check("nf_c4_en_out", en_out, 1'b1);
      check("nf_c4_ir", ir, 16'h2A37);
      check("nf_c4_fields", {opcode, rd, rs, imm}, {4'h2, 2'b10, 2'b10, 8'h37});
      check("nf_c4_addr", mem_addr, 8'h05);
      next_cycle();
      check("nf_c5_idle", {busy, en_out}, 2'b00);
      check("nf_pulses", {rd_cnt - rd_base, done_cnt - done_base}, {32'd1, 32'd1});

      // zero-wait fetch
      en_in = 1'b1; pc_addr = 8'h10;
      next_cycle();
      en_in = 1'b0; mem_valid = 1'b1; mem_rdata = 16'hA0F0;
      check("zw_c1_rd_en", mem_rd_en, 1'b1);
      check("zw_c1_addr", mem_addr, 8'h10);
      next_cycle();
      mem_valid = 1'b0;
      check("zw_c2_en_out", en_out, 1'b1);
      check("zw_c2_fields", {opcode, imm}, {4'hA, 8'hF0});
      next_cycle();
      check("zw_c3_idle", busy, 1'b0);

      // timeout, TIMEOUT=8: busy drops in cycle 10 with err set
      done_base = done_cnt;
      en_in = 1'b1; pc_addr = 8'h40;
      next_cycle();
      en_in = 1'b0;
      for (int c = 1; c <= 8; c++) next_cycle();
      check("to_c9_busy", busy, 1'b1);
      check("to_c9_err", err, 1'b0);
      next_cycle();
      check("to_c10_busy", busy, 1'b0);
      check("to_c10_err", err, 1'b1);
      check("to_ir_kept", ir, 16'hA0F0);
      check("to_no_done", done_cnt - done_base, 0);
      check("to_no_ovr", ovr, 1'b0);

      // following fetch succeeds, err stays
      en_in = 1'b1; pc_addr = 8'h41;
      next_cycle();
      en_in = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h1234;
      next_cycle();
      mem_valid = 1'b0;
      check("to_retry_done", en_out, 1'b1);
      check("to_retry_ir", ir, 16'h1234);
      check("to_err_sticky", err, 1'b1);
      next_cycle();

      // overrun: second en_in while in WAIT
      rd_base = rd_cnt; done_base = done_cnt;
      en_in = 1'b1; pc_addr = 8'h20;
      next_cycle();
      en_in = 1'b0;
      next_cycle();
      en_in = 1'b1; pc_addr = 8'h21;
      next_cycle();
      en_in = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h5A5A;
      check("ov_flag", ovr, 1'b1);
      next_cycle();
      mem_valid = 1'b0;
      check("ov_done", en_out, 1'b1);
      next_cycle();
      next_cycle();
      check("ov_pulses", {rd_cnt - rd_base, done_cnt - done_base}, {32'd1, 32'd1});
      check("ov_addr", mem_addr, 8'h20);
      check("ov_ir", ir, 16'h5A5A);

      // reset during WAIT, then late data must be ignored
      done_base = done_cnt;
      en_in = 1'b1; pc_addr = 8'h30;
      next_cycle();
      en_in = 1'b0;
      next_cycle();
      check("mr_in_wait", {busy, mem_rd_en}, 2'b10);
      #1 rst = 1'b1;
      #1;
      check("mr_busy", busy, 1'b0);
      check("mr_ir", ir, 16'h0000);
      check("mr_flags", {err, ovr, mem_addr}, {1'b0, 1'b0, 8'h00});
      next_cycle();
      rst = 1'b0;
      mem_valid = 1'b1; mem_rdata = 16'hFFFF;
      next_cycle();
      mem_valid = 1'b0;
      next_cycle();
      check("mr_late_ir", ir, 16'h0000);
      check("mr_late_idle", busy, 1'b0);
      check("mr_no_done", done_cnt - done_base, 0);

      // en_in and mem_valid together in IDLE: request accepted, data dropped
      en_in = 1'b1; pc_addr = 8'h33; mem_valid = 1'b1; mem_rdata = 16'hBEEF;
      next_cycle();
      en_in = 1'b0; mem_valid = 1'b0;
      check("iv_req", mem_rd_en, 1'b1);
      check("iv_ir_kept", ir, 16'h0000);
      next_cycle();
      mem_valid = 1'b1; mem_rdata = 16'h7777;
      next_cycle();
      mem_valid = 1'b0;
      check("iv_done", {en_out, ir}, {1'b1, 16'h7777});
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
